branch_logic: RTL and testbench



---
 rtl/branch_logic.sv | 53 +++++
 tb/tb_branch_logic.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/branch_logic.sv
// branch_logic: evaluates the conditional-branch decision for the PC-select path.
// Decodes the opcode, tests it against the ALU Z/N flags and registers the
// result. That registered bit is the PC mux select: 1 selects the branch target.
module branch_logic (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] opcode,
  input  logic [1:0] flags,
  output logic       pc_branch_sel_out
);

  // Conditional-branch opcode encodings.
  localparam logic [4:0] OP_BEQ = 5'b10011;
  localparam logic [4:0] OP_BLT = 5'b10100;
  localparam logic [4:0] OP_BGT = 5'b10101;
  localparam logic [4:0] OP_BNE = 5'b10110;

  logic flag_z;
  logic flag_n;
  logic take_d;
  logic take_q;

  assign flag_z = flags[1];
  assign flag_n = flags[0];

  // Branch condition: the flags are read only under a branch opcode, so X flags
  // seen with any other opcode never reach the flop.
  always_comb begin
    // NOTE: assign a default before the case so every path drives take_d; a missed path would infer a latch.
    take_d = 1'b0;
    case (opcode)
      OP_BEQ:  take_d = flag_z;
      OP_BNE:  take_d = ~flag_z;
      OP_BLT:  take_d = flag_n;
      // BGT means "not negative": zero results also take the branch.
      OP_BGT:  take_d = ~flag_n;
      default: take_d = 1'b0;
    endcase
  end

  // Select register: cleared asynchronously by reset, loads the condition on every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      take_q <= 1'b0;
    end else begin
      // NOTE: use non-blocking assignment for flop state so every register samples its pre-edge value.
      take_q <= take_d;
    end
  end

  assign pc_branch_sel_out = take_q;

endmodule

// File: tb/tb_branch_logic.sv
// Self-checking bench for branch_logic. Each drive pushes the expected select
// into a scoreboard queue. The value is popped and compared after the next
// rising edge.
module tb_branch_logic;

  localparam logic [4:0] BEQ = 5'b10011;
  localparam logic [4:0] BLT = 5'b10100;
  localparam logic [4:0] BGT = 5'b10101;
  localparam logic [4:0] BNE = 5'b10110;

  logic       clk;
  logic       rst_n;
  logic [4:0] opcode;
  logic [1:0] flags;
  logic       pc_branch_sel_out;

  int n_checks = 0;
  int n_errors = 0;
  logic exp_q[$];

  branch_logic dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .opcode            (opcode),
    .flags             (flags),
    .pc_branch_sel_out (pc_branch_sel_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stops a runaway simulation.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic actual, input logic expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Behavioural model of the branch condition.
  function automatic logic model(input logic [4:0] op, input logic [1:0] fl);
    logic z;
    logic n;
    z = fl[1];
    n = fl[0];
    if (op == BEQ) return z;
    if (op == BNE) return !z;
    if (op == BLT) return n;
    if (op == BGT) return !n;
    return 1'b0;
  endfunction

  // Drive one input pair at the falling edge. Score it after the next rising edge.
  task automatic step(input string tag, input logic [4:0] op, input logic [1:0] fl);
    logic exp;
    @(negedge clk);
    opcode = op;
    flags  = fl;
    exp_q.push_back(model(op, fl));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1'b1, 1'b0);
    end else begin
      exp = exp_q.pop_front();
      check(tag, pc_branch_sel_out, exp);
    end
  endtask

  logic [1:0] beq_fl[4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] bne_fl[4] = '{2'b01, 2'b00, 2'b11, 2'b10};
  logic [1:0] blt_fl[4] = '{2'b01, 2'b11, 2'b10, 2'b00};
  logic [1:0] bgt_fl[4] = '{2'b00, 2'b10, 2'b01, 2'b11};

  initial begin
    rst_n  = 1'b0;
    opcode = BEQ;
    flags  = 2'b10;
    #1;
    check("reset_async_initial", pc_branch_sel_out, 1'b0);

    // Reset held for 5 cycles while a taken BEQ is presented.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("reset_hold_%0d", i), pc_branch_sel_out, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step("reset_release_beq", BEQ, 2'b10);

    // Each branch type, each flag pattern held for two cycles.
    for (int i = 0; i < 4; i++) begin
      for (int h = 0; h < 2; h++) step($sformatf("beq_%b_%0d", beq_fl[i], h), BEQ, beq_fl[i]);
    end
    for (int i = 0; i < 4; i++) begin
      for (int h = 0; h < 2; h++) step($sformatf("bne_%b_%0d", bne_fl[i], h), BNE, bne_fl[i]);
    end
    for (int i = 0; i < 4; i++) begin
      for (int h = 0; h < 2; h++) step($sformatf("blt_%b_%0d", blt_fl[i], h), BLT, blt_fl[i]);
    end
    for (int i = 0; i < 4; i++) begin
      for (int h = 0; h < 2; h++) step($sformatf("bgt_%b_%0d", bgt_fl[i], h), BGT, bgt_fl[i]);
    end

    // Non-branch opcodes never take the branch, whatever the flag values.
    for (int f = 0; f < 4; f++) step($sformatf("nonbr_00000_%0d", f), 5'b00000, 2'(f));
    step("nonbr_10010", 5'b10010, 2'b10);
    step("nonbr_10111", 5'b10111, 2'b01);
    step("nonbr_x_flags", 5'b00000, 2'bxx);
    step("nonbr_11111_x", 5'b11111, 2'bx0);

    // Latency: an input change just after an edge is not visible until the next edge.
    step("lat_beq_taken", BEQ, 2'b10);
    opcode = 5'b11111;
    #2;
    check("lat_hold_after_change", pc_branch_sel_out, 1'b1);
    @(negedge clk);
    check("lat_hold_at_negedge", pc_branch_sel_out, 1'b1);
    @(posedge clk);
    #1;
    check("lat_cleared_next_edge", pc_branch_sel_out, model(5'b11111, 2'b10));

    // Opcode and flags change together: the new pair decides.
    step("simul_bgt_taken", BGT, 2'b10);
    step("simul_blt_not", BLT, 2'b00);

    // Reset asserted between edges while the output is 1.
    step("midrst_set", BNE, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_async_clear", pc_branch_sel_out, 1'b0);
    @(posedge clk);
    #1;
    check("midrst_held_low", pc_branch_sel_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step("midrst_resume", BNE, 2'b00);

    check("scoreboard_drained", exp_q.size() == 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
